mod_counter_ctrl: RTL and testbench

- Run controller for the team's modulo-N up-counter datapath. It holds the modulus and pass-count configuration and sequences start, stop and run-to-completion.
- The counter register is built in (WIDTH bits). Counting advances only on an external tick enable.
- Reports wrap events, pass progress, completion and configuration errors to the surrounding lab-top FSM.

---
 rtl/mod_counter_ctrl_if.sv | 29 ++
 rtl/mod_counter_ctrl.sv | 119 +++++++++++
 tb/tb_mod_counter_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_counter_ctrl_if.sv
// Handshake/config bundle between the lab-top FSM (master) and the
// modulo-N counter run controller (slave).
interface mod_counter_ctrl_if #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 8
);
  logic              cfg_we;
  logic [WIDTH:0]    cfg_mod;
  logic [PASS_W-1:0] cfg_passes;
  logic              start;
  logic              stop;
  logic              tick;
  logic [WIDTH-1:0]  q;
  logic              busy;
  logic              wrap;
  logic              done;
  logic [PASS_W-1:0] pass_cnt;
  logic              cfg_err;

  modport master (
    output cfg_we, cfg_mod, cfg_passes, start, stop, tick,
    input  q, busy, wrap, done, pass_cnt, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_mod, cfg_passes, start, stop, tick,
    output q, busy, wrap, done, pass_cnt, cfg_err
  );
endinterface

// File: rtl/mod_counter_ctrl.sv
// Run controller for a modulo-N up-counter: holds modulus/pass config,
// sequences start/stop/run-to-completion and reports wrap/done/cfg errors.
module mod_counter_ctrl #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_MOD = 9,
  parameter int PASS_W      = 8
) (
  input logic               clock,
  input logic               reset,
  mod_counter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [WIDTH:0]    MOD_MAX    = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]    MOD_RST    = (WIDTH+1)'(DEFAULT_MOD);
  localparam logic [PASS_W-1:0] PASSES_RST = PASS_W'(1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [WIDTH:0]    mod_q, mod_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              cfg_ok;
  logic              at_top;
  logic [PASS_W-1:0] pass_inc;

  assign cfg_ok   = (bus.cfg_mod >= (WIDTH+1)'(2)) && (bus.cfg_mod <= MOD_MAX);
  assign at_top   = ({1'b0, q_q} == (mod_q - 1'b1));
  assign pass_inc = pass_q + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      pass_q   <= '0;
      mod_q    <= MOD_RST;
      passes_q <= PASSES_RST;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      pass_q   <= pass_d;
      mod_q    <= mod_d;
      passes_q <= passes_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    pass_d   = pass_q;
    mod_d    = mod_q;
    passes_d = passes_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    // Config registers are only read in RUN, so a write outside RUN
    // naturally takes effect from the next start.
    if (state_q != RUN && bus.cfg_we) begin
      if (cfg_ok) begin
        mod_d    = bus.cfg_mod;
        passes_d = bus.cfg_passes;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          q_d     = '0;
          pass_d  = '0;
        end
      end
      RUN: begin
        err_d = bus.cfg_we;
        if (bus.tick) begin
          if (at_top) begin
            q_d    = '0;
            wrap_d = 1'b1;
            pass_d = pass_inc;
          end else begin
            q_d = q_q + 1'b1;
          end
        end
        // stop wins over completion but a coincident wrap is still reported
        if (bus.stop) begin
          state_d = IDLE;
          q_d     = '0;
        end else if (bus.tick && at_top && passes_q != '0 && pass_inc == passes_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.q        = q_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.wrap     = wrap_q;
  assign bus.done     = done_q;
  assign bus.pass_cnt = pass_q;
  assign bus.cfg_err  = err_q;

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Self-checking bench for mod_counter_ctrl: directed scenarios plus randomized
// runs scored against an arithmetic model (q = n mod M, passes = n div M).
module tb_mod_counter_ctrl;
  localparam int W  = 4;
  localparam int PW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  mod_counter_ctrl_if #(.WIDTH(W), .PASS_W(PW)) bus();

  mod_counter_ctrl #(.WIDTH(W), .DEFAULT_MOD(9), .PASS_W(PW)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.cfg_we = 1'b0; bus.cfg_mod = '0; bus.cfg_passes = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.tick = 1'b0;
  endtask

  task automatic cfg_write(input int m, input int p);
    bus.cfg_we = 1'b1; bus.cfg_mod = 5'(m); bus.cfg_passes = 8'(p);
    step();
    bus.cfg_we = 1'b0;
  endtask

  // {q, busy, wrap, done, pass_cnt, cfg_err}
  function automatic logic [15:0] obs();
    return {bus.q, bus.busy, bus.wrap, bus.done, bus.pass_cnt, bus.cfg_err};
  endfunction

  task automatic test_reset();
    logic [15:0] o;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cfg_we = 1'($urandom); bus.cfg_mod = 5'($urandom); bus.cfg_passes = 8'($urandom);
      bus.start = 1'($urandom); bus.stop = 1'($urandom); bus.tick = 1'($urandom);
      step();
      o = obs();
      n_tot++;
      if (o !== 16'h0) $display("FAIL reset_hold[%0d]: got %h exp 0000", i, o);
      else n_pass++;
    end
    idle_in();
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_default_run();
    logic [15:0] o, e;
    bus.start = 1'b1; bus.tick = 1'b1;
    step();
    o = obs();
    n_tot++;
    if (o !== {4'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0}) $display("FAIL default_entry: got %h exp run q=0", o);
    else n_pass++;
    bus.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      o = obs();
      e = {4'(k % 9), 1'(k != 9), 1'(k == 9), 1'(k == 9), 8'(k / 9), 1'b0};
      n_tot++;
      if (o !== e) $display("FAIL default_tick%0d: got %h exp %h", k, o, e);
      else n_pass++;
    end
    // start during the DONE cycle must be ignored
    bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.tick = 1'b0;
    o = obs();
    n_tot++;
    if (o !== {4'd0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0}) $display("FAIL default_after_done: got %h exp 0002", o);
    else n_pass++;
    step();
    n_tot++;
    if (bus.busy !== 1'b0) $display("FAIL default_idle: busy got %b exp 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_multipass();
    int nt = 0, wraps = 0, edges = 0;
    bit seen = 0;
    logic [6:0] o, e;
    cfg_write(5, 3);
    n_tot++;
    if (bus.cfg_err !== 1'b0) $display("FAIL multipass_cfg: cfg_err got %b exp 0", bus.cfg_err);
    else n_pass++;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c < 100 && !seen; c++) begin
      bus.tick = 1'(c % 2);
      step();
      nt += c % 2;
      o = {bus.q, bus.wrap, bus.done, bus.busy};
      e = {4'(nt % 5), 1'((c % 2) == 1 && nt % 5 == 0), 1'((c % 2) == 1 && nt == 15), 1'(nt != 15)};
      n_tot++;
      if (o !== e) $display("FAIL multipass_cyc%0d: got %h exp %h", c, o, e);
      else n_pass++;
      wraps += int'(bus.wrap);
      if (bus.done) begin seen = 1; edges = c + 1; end
    end
    bus.tick = 1'b0;
    n_tot++;
    if (!seen || wraps != 3 || edges != 30 || bus.pass_cnt !== 8'd3)
      $display("FAIL multipass_summary: done=%0d wraps=%0d edges=%0d pass=%0d exp 1/3/30/3", seen, wraps, edges, bus.pass_cnt);
    else n_pass++;
    step();
  endtask

  task automatic test_stop();
    logic [15:0] o;
    cfg_write(9, 0);
    bus.start = 1'b1; step(); bus.start = 1'b0; bus.tick = 1'b1;
    repeat (20) step();
    n_tot++;
    if ({bus.q, bus.pass_cnt, bus.busy} !== {4'd2, 8'd2, 1'b1})
      $display("FAIL freerun_20: q=%0d pass=%0d busy=%b exp 2/2/1", bus.q, bus.pass_cnt, bus.busy);
    else n_pass++;
    bus.stop = 1'b1; step(); bus.stop = 1'b0; bus.tick = 1'b0;
    o = obs();
    n_tot++;
    if (o !== {4'd0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0}) $display("FAIL stop_freerun: got %h exp 0004", o);
    else n_pass++;

    cfg_write(9, 1);
    bus.start = 1'b1; step(); bus.start = 1'b0; bus.tick = 1'b1;
    repeat (8) step();
    n_tot++;
    if (bus.q !== 4'd8) $display("FAIL stop_pre_wrap: q got %0d exp 8", bus.q);
    else n_pass++;
    bus.stop = 1'b1; step(); bus.stop = 1'b0; bus.tick = 1'b0;
    o = obs();
    n_tot++;
    if (o !== {4'd0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0}) $display("FAIL stop_on_wrap: got %h exp 0402", o);
    else n_pass++;
    step();
    n_tot++;
    if ({bus.wrap, bus.done, bus.busy} !== 3'b000) $display("FAIL stop_wrap_pulse: wdb got %b exp 000", {bus.wrap, bus.done, bus.busy});
    else n_pass++;

    bus.start = 1'b1; bus.stop = 1'b1; bus.tick = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    step();
    bus.tick = 1'b0;
    n_tot++;
    if ({bus.busy, bus.q} !== 5'd0) $display("FAIL start_stop_idle: busy=%b q=%0d exp 0/0", bus.busy, bus.q);
    else n_pass++;
  endtask

  task automatic test_cfg_err();
    logic [6:0] o, e;
    bus.cfg_we = 1'b1; bus.cfg_mod = 5'd1; bus.cfg_passes = 8'd5;
    step();
    n_tot++;
    if (bus.cfg_err !== 1'b1) $display("FAIL cfg_err_mod1: got %b exp 1", bus.cfg_err);
    else n_pass++;
    bus.cfg_mod = 5'd17; bus.cfg_passes = 8'd7;
    step();
    n_tot++;
    if (bus.cfg_err !== 1'b1) $display("FAIL cfg_err_mod17: got %b exp 1", bus.cfg_err);
    else n_pass++;
    bus.cfg_we = 1'b0;
    step();
    n_tot++;
    if (bus.cfg_err !== 1'b0) $display("FAIL cfg_err_pulse: got %b exp 0", bus.cfg_err);
    else n_pass++;
    // mod 9 / 1 pass must still be in force; a write during RUN is refused
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.tick = 1'b1; bus.cfg_we = 1'b1; bus.cfg_mod = 5'd3; bus.cfg_passes = 8'd2;
    step();
    bus.cfg_we = 1'b0;
    n_tot++;
    if ({bus.cfg_err, bus.q, bus.busy} !== {1'b1, 4'd1, 1'b1}) $display("FAIL cfg_we_in_run: err=%b q=%0d busy=%b exp 1/1/1", bus.cfg_err, bus.q, bus.busy);
    else n_pass++;
    for (int k = 2; k <= 9; k++) begin
      step();
      o = {bus.q, bus.wrap, bus.done, bus.cfg_err};
      e = {4'(k % 9), 1'(k == 9), 1'(k == 9), 1'b0};
      n_tot++;
      if (o !== e) $display("FAIL cfg_err_run_tick%0d: got %h exp %h", k, o, e);
      else n_pass++;
    end
    bus.tick = 1'b0;
    step();
  endtask

  task automatic test_random_runs();
    logic [15:0] o, e;
    for (int r = 0; r < 25; r++) begin
      int m = int'($urandom_range(2, 16));
      int p = int'($urandom_range(0, 3));
      int prob = int'($urandom_range(30, 100));
      int n = 0;
      bit active = 1;
      logic [3:0] qe;
      logic [7:0] pe;
      logic we, tk, sp, w, de;
      cfg_write(m, p);
      bus.start = 1'b1; bus.tick = 1'($urandom);
      step();
      bus.start = 1'b0;
      n_tot++;
      if ({bus.busy, bus.q, bus.cfg_err} !== {1'b1, 4'd0, 1'b0}) $display("FAIL rand%0d_entry: busy=%b q=%0d err=%b", r, bus.busy, bus.q, bus.cfg_err);
      else n_pass++;
      pe = 8'd0;
      for (int c = 0; c < 200 && active; c++) begin
        tk = 1'(int'($urandom_range(0, 99)) < prob);
        sp = 1'(($urandom % 40) == 0 || c == 150);
        we = 1'(($urandom % 16) == 0);
        bus.tick = tk; bus.stop = sp; bus.cfg_we = we;
        bus.cfg_mod = 5'($urandom); bus.cfg_passes = 8'($urandom);
        step();
        if (tk) n++;
        w  = tk && (n % m == 0);
        qe = 4'(n % m);
        pe = 8'(n / m);
        de = 1'b0;
        if (sp) begin
          qe = 4'd0; active = 0;
        end else if (p != 0 && w && n / m == p) begin
          de = 1'b1; active = 0;
        end
        e = {qe, 1'(active), w, de, pe, we};
        o = obs();
        n_tot++;
        if (o !== e) $display("FAIL rand%0d_cyc%0d: got %h exp %h (m=%0d p=%0d n=%0d)", r, c, o, e, m, p, n);
        else n_pass++;
      end
      n_tot++;
      if (active) $display("FAIL rand%0d_timeout: run still active got 1 exp 0", r);
      else n_pass++;
      idle_in();
      step();
      o = obs();
      n_tot++;
      if (o !== {4'd0, 1'b0, 1'b0, 1'b0, pe, 1'b0}) $display("FAIL rand%0d_idle: got %h exp %h", r, o, {4'd0, 3'b0, pe, 1'b0});
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] o;
    logic [6:0]  s, e;
    cfg_write(12, 0);
    bus.start = 1'b1; step(); bus.start = 1'b0; bus.tick = 1'b1;
    repeat (6) step();
    bus.tick = 1'b0;
    n_tot++;
    if (bus.q !== 4'd6) $display("FAIL areset_pre: q got %0d exp 6", bus.q);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1 o = obs();
    n_tot++;
    if (o !== 16'h0) $display("FAIL areset_immediate: got %h exp 0000", o);
    else n_pass++;
    #2 rst_n = 1'b1;
    bus.start = 1'b1; step(); bus.start = 1'b0; bus.tick = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      s = {bus.q, bus.wrap, bus.done, bus.busy};
      e = {4'(k % 9), 1'(k == 9), 1'(k == 9), 1'(k != 9)};
      n_tot++;
      if (s !== e) $display("FAIL areset_defaults_tick%0d: got %h exp %h", k, s, e);
      else n_pass++;
    end
    bus.tick = 1'b0;
    step();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_default_run();
    test_multipass();
    test_stop();
    test_cfg_err();
    test_random_runs();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
